// File: rtl/fredkin_pkg.sv
// Shared constants and helpers for the Fredkin swap pipeline.
// Holds the transfer-counter width and saturation value, plus the popcount
// helper used by the optional conservation checker (FREDKIN_REVCHK_EN).
package fredkin_pkg;

  // Width of the completed-transfer counter.
  localparam int TXN_W = 16;

  // The counter sticks at this value instead of wrapping.
  localparam logic [TXN_W-1:0] TXN_SAT = 16'hFFFF;

  // Widest legal data word.
  localparam int MAX_W = 64;

  // Wide enough to count every bit of three maximum-width words (3*64 = 192).
  localparam int PC_W = 8;

  // Counts the ones in a word of up to MAX_W bits. Narrower words are
  // zero-extended by the caller.
  function automatic logic [PC_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fredkin_pipe_stage.sv
// One elastic pipeline register stage: a valid bit, a data word and a ready
// signal chained back to the upstream stage. The stage takes a new word
// whenever it is empty or its current word leaves this cycle. It holds its
// contents while the downstream side stalls.
module fredkin_pipe_stage
  import fredkin_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q;
  logic          valid_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;

  // Room exists when the stage is empty or its word is leaving.
  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next state: load on a handshake, empty out when the word leaves with nothing behind it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Stage register; reset empties the stage and clears the data word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fredkin_swap_pipe.sv
// Fredkin (controlled-swap) gate on WIDTH-bit words, followed by STAGES
// elastic register stages with valid/ready handshakes on both sides.
// For each bit: p = a, and b/c are swapped into q/r wherever a is set.
// The gate is purely combinational in front of stage 0. Later stages only
// move the word along.
// Optional feature: define FREDKIN_REVCHK_EN to carry the input popcount
// beside each word. It is rechecked on every output transfer. A mismatch
// sets a sticky cons_err flag. Without the macro, cons_err is tied low.
module fredkin_swap_pipe
  import fredkin_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic [TXN_W-1:0] txn_cnt,
  output logic             cons_err
);

  localparam int WORD_W = 3 * WIDTH;
`ifdef FREDKIN_REVCHK_EN
  localparam int DW = WORD_W + PC_W;
`else
  localparam int DW = WORD_W;
`endif

  logic [WIDTH-1:0]         pGate;
  logic [WIDTH-1:0]         qGate;
  logic [WIDTH-1:0]         rGate;
  logic [STAGES:0]          linkValid;
  logic [STAGES:0]          linkReady;
  logic [STAGES:0][DW-1:0]  linkData;
  logic                     outXfer;
  logic [TXN_W-1:0]         txnCount_q;
  logic [TXN_W-1:0]         txnCount_d;

  // Controlled swap: where a is set, b and c trade places; a passes through.
  always_comb begin
    pGate = a_in;
    qGate = (a_in & c_in) | (~a_in & b_in);
    rGate = (a_in & b_in) | (~a_in & c_in);
  end

`ifdef FREDKIN_REVCHK_EN
  logic [PC_W-1:0] inPopCount;
  logic [PC_W-1:0] outPopCount;
  logic [PC_W-1:0] carriedPopCount;
  logic            consErr_q;
  logic            consErr_d;

  // The popcount of the original operands travels with the word.
  always_comb begin
    inPopCount = popcount(MAX_W'(a_in)) + popcount(MAX_W'(b_in))
               + popcount(MAX_W'(c_in));
  end

  assign linkData[0] = {inPopCount, pGate, qGate, rGate};
`else
  assign linkData[0] = {pGate, qGate, rGate};
`endif

  assign linkValid[0]      = in_valid;
  assign linkReady[STAGES] = out_ready;

  // Reset blocks new words even though the emptied stage 0 would have room.
  assign in_ready = linkReady[0] & ~rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    fredkin_pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (linkValid[k]),
      .in_ready (linkReady[k]),
      .in_data  (linkData[k]),
      .out_valid(linkValid[k+1]),
      .out_ready(linkReady[k+1]),
      .out_data (linkData[k+1])
    );
  end

  assign out_valid = linkValid[STAGES];
  assign p_out     = linkData[STAGES][3*WIDTH-1:2*WIDTH];
  assign q_out     = linkData[STAGES][2*WIDTH-1:WIDTH];
  assign r_out     = linkData[STAGES][WIDTH-1:0];
  assign outXfer   = out_valid & out_ready;
  assign txn_cnt   = txnCount_q;

  // Count completed output transfers, sticking at the saturation value.
  always_comb begin
    txnCount_d = txnCount_q;
    if (outXfer && (txnCount_q != TXN_SAT)) begin
      txnCount_d = txnCount_q + 1'b1;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txnCount_q <= '0;
    end else begin
      txnCount_q <= txnCount_d;
    end
  end

`ifdef FREDKIN_REVCHK_EN
  assign carriedPopCount = linkData[STAGES][DW-1:WORD_W];

  // On each transfer, compare the outgoing popcount with the carried one.
  always_comb begin
    outPopCount = popcount(MAX_W'(p_out)) + popcount(MAX_W'(q_out))
                + popcount(MAX_W'(r_out));
    consErr_d   = consErr_q;
    if (outXfer && (outPopCount != carriedPopCount)) begin
      consErr_d = 1'b1;
    end
  end

  // Sticky violation flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      consErr_q <= 1'b0;
    end else begin
      consErr_q <= consErr_d;
    end
  end

  assign cons_err = consErr_q;
`else
  assign cons_err = 1'b0;
`endif

endmodule

// File: doc/fredkin_swap_pipe.md
FREDKIN_SWAP_PIPE -- requirements
Module: fredkin_swap_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per data word (legal 1..64).
REQ-002 SHALL have parameter STAGES, default 2, meaning pipeline register stages (legal 1..4).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream word valid.
REQ-006 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port a_in  input  WIDTH  per-bit swap control.
REQ-008 SHALL have port b_in  input  WIDTH  first data operand.
REQ-009 SHALL have port c_in  input  WIDTH  second data operand.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have ports p_out, q_out, r_out  output  WIDTH each  Fredkin results.
REQ-013 SHALL have port txn_cnt  output  16  completed-transfer count.
REQ-014 SHALL have port cons_err  output  1  sticky conservation-violation flag (REVCHK_EN only).

Function
REQ-015 SHALL compute per bit i: p[i]=a[i]; q[i]=a[i]?c[i]:b[i]; r[i]=a[i]?b[i]:c[i].
REQ-016 SHALL accept a word when in_valid and in_ready both high at a rising edge.
REQ-017 SHALL present a result when out_valid high; transfer completes when out_valid and out_ready both high.
REQ-018 SHALL have latency exactly STAGES cycles from accept to out_valid with out_ready held high.
REQ-019 SHALL sustain one word per cycle with out_ready high; no bubbles inserted.
REQ-020 SHALL hold p_out/q_out/r_out/out_valid stable while out_valid high and out_ready low.
REQ-021 SHALL drive in_ready = (stage 0 empty) or (stage 0 advancing this cycle); full pipe with out_ready low SHALL drive in_ready low.
REQ-022 SHALL keep at most STAGES words in flight, in order, none dropped or duplicated.
REQ-023 SHALL increment txn_cnt on each output transfer, saturating at 16'hFFFF.
REQ-024 SHALL perform the Fredkin function combinationally ahead of stage 0; later stages are pure registers.

Reset
REQ-025 SHALL on rst high clear all stage valid bits asynchronously; out_valid=0, in_ready=0 while rst high.
REQ-026 SHALL reset p_out, q_out, r_out to all-zero, txn_cnt to 0, cons_err to 0.
REQ-027 SHALL drop in-flight words on reset mid-operation; first cycle after release in_ready=1.

Configuration
REQ-028 SHALL compile the conservation checker only when macro FREDKIN_REVCHK_EN is defined.
REQ-029 With FREDKIN_REVCHK_EN: on each output transfer, popcount(p,q,r) SHALL equal popcount of the originating (a,b,c), carried alongside the word; mismatch SHALL set cons_err, held until rst.
REQ-030 Without FREDKIN_REVCHK_EN: cons_err SHALL be tied 0; no popcount logic or sideband registers synthesised.

Structure
REQ-031 SHALL place the txn_cnt width constant (16), the saturation value and a popcount function in shared package fredkin_pkg.
REQ-032 SHALL implement one pipeline register stage (valid, data, ready chain) as sub-module fredkin_pipe_stage, instantiated STAGES times by generate.

Verification
REQ-033 WIDTH=8: a=8'hF0, b=8'hAA, c=8'h55 -> p=F0, q=5A, r=A5 exactly STAGES cycles later.
REQ-034 STAGES=2, out_ready low, 3 words offered -> 2 accepted, in_ready low, outputs frozen; out_ready high -> all 3 emerge in order.
REQ-035 Back-to-back 100 random words, out_ready high -> 100 results, one per cycle, txn_cnt=100; replaying (p,q,r) as input returns original (a,b,c).
REQ-036 rst asserted with 2 words in flight -> out_valid=0 immediately, txn_cnt=0, no stale word after release.
REQ-037 FREDKIN_REVCHK_EN, force-flip q_out bit 0 inside stage via bench override -> cons_err=1 on that transfer and stays 1 until rst.
REQ-038 txn_cnt preloaded to 16'hFFFE via 2 extra transfers -> reads 16'hFFFF and holds after a third transfer.
